// File: rtl/fifo_256_pkg.sv
// Shared constants and helpers for the fifo_256 write-side logic.
package fifo_256_pkg;

    localparam int WORD_W  = 16;
    localparam int N_WORDS = 16;
    localparam int BUS_W   = WORD_W * N_WORDS;

    // Raw size field 0 stands for a full 16-word write.
    function automatic logic [4:0] size2words(input logic [3:0] s);
        return (s == 4'd0) ? 5'd16 : {1'b0, s};
    endfunction

endpackage

// File: rtl/fifo_256_wr_arb_rr_arb.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;

    always_comb begin
        // Low half keeps only indices >= ptr, high half is the wrapped-around copy.
        hi_mask = ~((N'(1) << ptr) - N'(1));
        dbl     = {elig, elig & hi_mask};
        any     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int unsigned k = 0; k < 2 * N; k++) begin
            if (!any && dbl[k]) begin
                any     = 1'b1;
                gnt_idx = (k >= N) ? IW'(k - N) : IW'(k);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_256_wr_arb.sv
// Round-robin, credit-gated scheduler sharing the fifo_256 wide write port.
module fifo_256_wr_arb
    import fifo_256_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_WORDS = 256,
    parameter int CW         = $clog2(FIFO_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       reset_p,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*BUS_W-1:0]     req_data,
    input  logic [N_REQ*4-1:0]         req_size,
    output logic [BUS_W-1:0]           fifo_data_o,
    output logic [3:0]                 fifo_size_o,
    output logic                       fifo_we_o,
    input  logic                       fifo_rd_i,
    input  logic                       fifo_full_i,
    output logic [CW-1:0]              credit_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       err_o
);

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             any;

    logic [CW-1:0]    credit_q, credit_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [BUS_W-1:0] data_q, data_d;
    logic [3:0]       size_q, size_d;
    logic [IW-1:0]    id_q, id_d;
    logic             we_q, we_d;

    logic [3:0]       gsize;
    logic [4:0]       gwords;
    logic             rd_ok;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i]
                   && (CW'(size2words(req_size[i*4 +: 4])) <= credit_q)
                   && !fifo_full_i
                   && !reset_p;
        end
    end

    rr_arb #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arb (
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign req_ready = gnt;

    always_comb begin
        gsize  = req_size[int'(gnt_idx)*4 +: 4];
        gwords = size2words(gsize);
        // A read while already at full credit cannot return a word; flag it instead.
        rd_ok  = fifo_rd_i && (credit_q != CW'(FIFO_WORDS));

        credit_d = credit_q - (any ? CW'(gwords) : '0) + (rd_ok ? CW'(1) : '0);
        err_d    = err_q | (fifo_rd_i & ~rd_ok);

        ptr_d = ptr_q;
        if (any) begin
            ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end

        we_d   = any;
        data_d = any ? req_data[int'(gnt_idx)*BUS_W +: BUS_W] : data_q;
        size_d = any ? gsize : size_q;
        id_d   = any ? gnt_idx : id_q;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            credit_q <= CW'(FIFO_WORDS);
            ptr_q    <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            data_q   <= '0;
            size_q   <= '0;
            id_q     <= '0;
        end else begin
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            we_q     <= we_d;
            data_q   <= data_d;
            size_q   <= size_d;
            id_q     <= id_d;
        end
    end

    assign credit_o    = credit_q;
    assign err_o       = err_q;
    assign fifo_we_o   = we_q;
    assign fifo_data_o = data_q;
    assign fifo_size_o = size_q;
    assign grant_id_o  = id_q;

endmodule
